// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_slice_4bit.sv
// Combinational 4-bit ripple adder slice. Operand inversion for subtraction is
// handled by the controller; this slice only adds. c3 is the carry into bit 3,
// used by the controller to derive signed overflow on the top nibble.
module addsub_slice_4bit
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  // Four chained full adders, carry rippling from bit 0 upward.
  always_comb begin
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor. One 4-bit slice is reused for
// every nibble, LSB first, with the carry held in a register between nibbles.
// Operands arrive on an in_valid/in_ready handshake and the result leaves on
// an out_valid/out_ready handshake.
module addsub_serial_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovfl,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  // Reject widths the nibble sequencer cannot handle.
  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("addsub_serial_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic                           carry;
  logic [NIB-1:0][NIBBLE_W-1:0]   a_q;
  logic [NIB-1:0][NIBBLE_W-1:0]   b_q;
  logic                           sub_q;
  logic [NIB-1:0][NIBBLE_W-1:0]   res_q;

  logic [NIBBLE_W-1:0]            s_a;
  logic [NIBBLE_W-1:0]            s_b;
  logic [NIBBLE_W-1:0]            s_sum;
  logic                           s_cout;
  logic                           s_c3;

  logic                           accept;

  assign accept = (state == IDLE) && in_valid;

  // Subtraction is A + ~B + 1: invert B here, the +1 enters as the initial carry.
  assign s_a = a_q[idx];
  assign s_b = b_q[idx] ^ {NIBBLE_W{sub_q}};

  addsub_slice_4bit u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout),
    .c3   (s_c3)
  );

  // Operand capture on accept; later input changes are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  // Sequencer FSM: IDLE accepts, RUN walks the nibbles, DONE holds until released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      res_q     <= '0;
      cout      <= 1'b0;
      ovfl      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry    <= sub;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res_q[idx] <= s_sum;
          carry      <= s_cout;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            idx       <= '0;
            cout      <= s_cout;
            ovfl      <= s_c3 ^ s_cout;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Self-checking bench for addsub_serial_ctrl at WIDTH=16.
module tb_addsub_serial_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovfl;
  logic         busy;

  int checks = 0;
  int errors = 0;

  addsub_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovfl      (ovfl),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on the operands. Returns {ovfl, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    longint ux, uy, sx, sy, sr, ur;
    logic   c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= (64'sd1 << (W-1))) ? ux - (64'sd1 << W) : ux;
    sy = (uy >= (64'sd1 << (W-1))) ? uy - (64'sd1 << W) : uy;
    if (s) begin
      sr = sx - sy;
      ur = ux - uy;
      c  = (ux >= uy);
    end else begin
      sr = sx + sy;
      ur = ux + uy;
      c  = (ur >= (64'sd1 << W));
    end
    v = (sr > ((64'sd1 << (W-1)) - 1)) || (sr < -(64'sd1 << (W-1)));
    return {v, c, ur[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corners [6];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  // Wait (bounded) for out_valid; k counts negedges after the accept edge.
  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    if (ovfl !== 1'b0) begin errors++; $display("FAIL reset_ovfl got %b exp 0", ovfl); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vs [4];
    logic [W-1:0] er [4];
    logic         ec [4];
    logic         ev [4];
    int k;
    va = '{16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF};
    vb = '{16'h0001, 16'h0007, 16'h0001, 16'h0001};
    vs = '{1'b0, 1'b1, 1'b1, 1'b0};
    er = '{16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
    ec = '{1'b0, 1'b0, 1'b1, 1'b1};
    ev = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b exp 1", i, in_ready); end
      a = va[i]; b = vb[i]; sub = vs[i]; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sub = ~sub;
      wait_out(k);
      checks += 4;
      if (k !== 4) begin errors++; $display("FAIL dir%0d_latency got %0d exp 4", i, k); end
      if (result !== er[i]) begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, result, er[i]); end
      if (cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", i, cout, ec[i]); end
      if (ovfl !== ev[i]) begin errors++; $display("FAIL dir%0d_ovfl got %b exp %b", i, ovfl, ev[i]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_release_out_valid got %b exp 0", i, out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_release_in_ready got %b exp 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xa, xb, na, nb;
    logic         xs, ns;
    logic [W+1:0] exp1, exp2;
    int k;
    xa = rand_operand(); xb = rand_operand(); xs = 1'($urandom);
    exp1 = model(xa, xb, xs);
    a = xa; b = xb; sub = xs; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    checks++;
    if (k !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", k); end
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(negedge clk);
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got %b exp 1", j, out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got %b exp 0", j, in_ready); end
      if (result !== exp1[W-1:0]) begin errors++; $display("FAIL bp%0d_result got %h exp %h", j, result, exp1[W-1:0]); end
      if (cout !== exp1[W]) begin errors++; $display("FAIL bp%0d_cout got %b exp %b", j, cout, exp1[W]); end
      if (ovfl !== exp1[W+1]) begin errors++; $display("FAIL bp%0d_ovfl got %b exp %b", j, ovfl, exp1[W+1]); end
    end
    na = rand_operand(); nb = rand_operand(); ns = 1'($urandom);
    exp2 = model(na, nb, ns);
    a = na; b = nb; sub = ns; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_new_accept in_ready got %b exp 0", in_ready); end
    wait_out(k);
    checks += 4;
    if (k !== 4) begin errors++; $display("FAIL bp_new_latency got %0d exp 4", k); end
    if (result !== exp2[W-1:0]) begin errors++; $display("FAIL bp_new_result got %h exp %h", result, exp2[W-1:0]); end
    if (cout !== exp2[W]) begin errors++; $display("FAIL bp_new_cout got %b exp %b", cout, exp2[W]); end
    if (ovfl !== exp2[W+1]) begin errors++; $display("FAIL bp_new_ovfl got %b exp %b", ovfl, exp2[W+1]); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int k;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    if (result !== 16'h0000) begin errors++; $display("FAIL midrst_result got %h exp 0000", result); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    checks += 4;
    if (k !== 4) begin errors++; $display("FAIL midrst_op_latency got %0d exp 4", k); end
    if (result !== 16'h5555) begin errors++; $display("FAIL midrst_op_result got %h exp 5555", result); end
    if (cout !== 1'b0) begin errors++; $display("FAIL midrst_op_cout got %b exp 0", cout); end
    if (ovfl !== 1'b0) begin errors++; $display("FAIL midrst_op_ovfl got %b exp 0", ovfl); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [W+1:0] q [$];
    logic [W+1:0] e;
    int issued = 0;
    int last = -1;
    int cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (cyc < 400) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_output got %h exp none", result);
        end else begin
          e = q.pop_front();
          if ({ovfl, cout, result} !== e)
            begin errors++; $display("FAIL b2b_result got %b_%b_%h exp %b_%b_%h", ovfl, cout, result, e[W+1], e[W], e[W-1:0]); end
        end
      end
      if (issued == N && q.size() == 0) begin
        in_valid = 1'b0;
        break;
      end
      if (in_ready && issued < N) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 6) begin errors++; $display("FAIL b2b_interval got %0d exp 6", cyc - last); end
        end
        a = rand_operand(); b = rand_operand(); sub = 1'($urandom);
        q.push_back(model(a, b, sub));
        issued++;
        last = cyc;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (issued != N || q.size() != 0) begin
      errors++; $display("FAIL b2b_timeout got %0d issued %0d pending exp %0d issued 0 pending", issued, q.size(), N);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
